// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage controller between EX/MEM and the data memory.
// Issues one-cycle read/write strobes and presents a registered WB bundle.
module mem_access_stage #(
    parameter int DEPTH  = 10,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_reg_write,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [REG_W-1:0]  in_rd,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic              wb_reg_write,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_fault
);

    typedef enum logic [1:0] {IDLE, RD, WR, OUT} state_t;

    state_t state;
    state_t state_next;
    logic   accept;
    logic   fault;
    logic   is_load;
    logic   is_store;
    logic   ld_reg_write;

    // Handshake and classification of the incoming instruction
    always_comb begin
        in_ready = (state == IDLE) | ((state == OUT) & wb_ready);
        accept   = in_valid & in_ready;
        fault    = ((in_mem_read | in_mem_write) &
                    (in_alu_result >= DATA_W'(DEPTH))) |
                   (in_mem_read & in_mem_write);
        is_load  = in_mem_read & ~fault;
        is_store = in_mem_write & ~fault;
    end

    // Next-state selection
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, OUT: begin
                if (accept) begin
                    if (is_load)       state_next = RD;
                    else if (is_store) state_next = WR;
                    else               state_next = OUT;
                end else if (state == OUT && wb_ready) begin
                    state_next = IDLE;
                end
            end
            RD:      state_next = OUT;
            WR:      state_next = OUT;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Memory strobes and writeback bundle; strobes last one cycle only
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_address  <= '0;
            mem_wdata    <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_fault     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            ld_reg_write <= 1'b0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (accept) begin
                wb_rd <= in_rd;
                if (fault) begin
                    wb_valid     <= 1'b1;
                    wb_fault     <= 1'b1;
                    wb_reg_write <= 1'b0;
                    wb_data      <= in_alu_result;
                end else if (is_load) begin
                    mem_read     <= 1'b1;
                    mem_address  <= in_alu_result;
                    ld_reg_write <= in_reg_write;
                    wb_valid     <= 1'b0;
                    wb_fault     <= 1'b0;
                    wb_reg_write <= 1'b0;
                end else if (is_store) begin
                    mem_write    <= 1'b1;
                    mem_address  <= in_alu_result;
                    mem_wdata    <= in_store_data;
                    wb_valid     <= 1'b0;
                    wb_fault     <= 1'b0;
                    wb_reg_write <= 1'b0;
                end else begin
                    wb_valid     <= 1'b1;
                    wb_fault     <= 1'b0;
                    wb_reg_write <= in_reg_write;
                    wb_data      <= in_alu_result;
                end
            end else if (state == RD) begin
                wb_valid     <= 1'b1;
                wb_data      <= mem_rdata;
                wb_reg_write <= ld_reg_write;
            end else if (state == WR) begin
                wb_valid     <= 1'b1;
                wb_data      <= mem_address;
                wb_reg_write <= 1'b0;
            end else if (state == OUT && wb_ready) begin
                wb_valid     <= 1'b0;
                wb_reg_write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: random instruction stream against a cycle-count
// reference model, plus directed reset-during-access checks.
module tb_mem_access_stage;

    localparam int DEPTH = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_mem_read;
    logic        in_mem_write;
    logic        in_reg_write;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [4:0]  in_rd;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_fault;

    mem_access_stage #(.DEPTH(DEPTH), .DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_reg_write(in_reg_write), .in_alu_result(in_alu_result),
        .in_store_data(in_store_data), .in_rd(in_rd),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_fault(wb_fault)
    );

    always #5 clk = ~clk;

    // Data memory: read data follows the strobe, writes land on clk edge
    logic [31:0] mem_arr [0:DEPTH-1];
    assign mem_rdata = (mem_read && mem_address < DEPTH) ?
                       mem_arr[mem_address[3:0]] : 32'd0;
    always @(posedge clk)
        if (mem_write && mem_address < DEPTH)
            mem_arr[mem_address[3:0]] <= mem_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one outstanding instruction, visible from cycle due
    logic [31:0] mdl_mem [0:DEPTH-1];
    bit          busy;
    int          c;
    int          acc;
    int          due;
    int          kind;
    logic [38:0] exp_bundle;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;

    task automatic drive_idle();
        in_valid      = 1'b0;
        in_mem_read   = 1'b0;
        in_mem_write  = 1'b0;
        in_reg_write  = 1'b0;
        in_alu_result = 32'd0;
        in_store_data = 32'd0;
        in_rd         = 5'd0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem"},
              {mem_read, mem_write, mem_address, mem_wdata}, 64'd0);
        check({tag, "_wb"},
              {wb_valid, wb_reg_write, wb_fault, wb_rd, wb_data}, 64'd0);
    endtask

    task automatic step_random();
        bit          vis;
        bit          rdy;
        bit          exp_rdy;
        bit          flt;
        int          op;
        @(negedge clk);
        vis = busy && c >= due;
        check("wb_valid", wb_valid, vis);
        if (vis)
            check("bundle", {wb_reg_write, wb_fault, wb_rd, wb_data},
                  exp_bundle);
        check("mem_read", mem_read, busy && kind == 1 && c == acc + 1);
        check("mem_write", mem_write, busy && kind == 2 && c == acc + 1);
        if (busy && (kind == 1 || kind == 2) && c == acc + 1)
            check("mem_address", mem_address, exp_addr);
        if (busy && kind == 2 && c == acc + 1)
            check("mem_wdata", mem_wdata, exp_wdata);

        rdy           = ($urandom_range(0, 3) != 0);
        wb_ready      = rdy;
        in_valid      = ($urandom_range(0, 9) < 7);
        in_rd         = 5'($urandom);
        in_reg_write  = 1'($urandom);
        in_store_data = $urandom;
        op            = $urandom_range(0, 9);
        in_mem_read   = (op >= 3 && op <= 5) || op == 9;
        in_mem_write  = (op >= 6);
        if (op <= 2) in_alu_result = $urandom;
        else         in_alu_result = 32'($urandom_range(0, DEPTH + 1));
        #1;
        exp_rdy = !busy || (vis && rdy);
        check("in_ready", in_ready, exp_rdy);

        if (vis && rdy) busy = 1'b0;
        if (in_valid && exp_rdy) begin
            flt = ((in_mem_read || in_mem_write) && in_alu_result >= DEPTH) ||
                  (in_mem_read && in_mem_write);
            busy = 1'b1;
            acc  = c;
            if (flt) begin
                kind       = 3;
                due        = c + 1;
                exp_bundle = {1'b0, 1'b1, in_rd, in_alu_result};
            end else if (in_mem_read) begin
                kind       = 1;
                due        = c + 2;
                exp_addr   = in_alu_result;
                exp_bundle = {in_reg_write, 1'b0, in_rd,
                              mdl_mem[int'(in_alu_result)]};
            end else if (in_mem_write) begin
                kind       = 2;
                due        = c + 2;
                exp_addr   = in_alu_result;
                exp_wdata  = in_store_data;
                exp_bundle = {1'b0, 1'b0, in_rd, in_alu_result};
                mdl_mem[int'(in_alu_result)] = in_store_data;
            end else begin
                kind       = 0;
                due        = c + 1;
                exp_bundle = {in_reg_write, 1'b0, in_rd, in_alu_result};
            end
        end
        c++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        wb_ready = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("idle");
        check("idle_in_ready", in_ready, 1'b1);
        busy = 1'b0;
        kind = 0;
    endtask

    initial begin
        reset    = 1'b1;
        wb_ready = 1'b1;
        drive_idle();
        busy = 1'b0;
        c    = 0;
        acc  = 0;
        due  = 0;
        kind = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_arr[i] = $urandom;
            mdl_mem[i] = mem_arr[i];
        end
        do_reset();

        for (int i = 0; i < 600; i++) step_random();

        // Reset while a load is in flight
        do_reset();
        in_valid      = 1'b1;
        in_mem_read   = 1'b1;
        in_reg_write  = 1'b1;
        in_alu_result = 32'd2;
        in_rd         = 5'd5;
        @(negedge clk);
        drive_idle();
        check("rd_strobe", {mem_read, mem_address}, {1'b1, 32'd2});
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("rd_reset");
        check("rd_reset_ready", in_ready, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check("rd_after_valid", wb_valid, 1'b0);

        // Reset while a store is in flight: the write still lands
        in_valid      = 1'b1;
        in_mem_write  = 1'b1;
        in_alu_result = 32'd4;
        in_store_data = 32'd99;
        in_rd         = 5'd7;
        @(negedge clk);
        drive_idle();
        check("wr_strobe", {mem_write, mem_address[3:0], mem_wdata},
              {1'b1, 4'd4, 32'd99});
        reset = 1'b1;
        @(negedge clk);
        check("wr_committed", mem_arr[4], 32'd99);
        check_all_zero("wr_reset");
        reset = 1'b0;
        @(negedge clk);
        check("wr_after_valid", wb_valid, 1'b0);
        mdl_mem[4] = 32'd99;
        busy = 1'b0;

        for (int i = 0; i < 300; i++) step_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM-stage controller between the EX/MEM boundary and the 32-bit data memory.
- Accepts one instruction per handshake.
- Sequences memory read/write strobes: reads are triggered on the memory's rising read edge, and writes are committed on the memory's clock edge while its write enable is high.
- Captures load data and presents a registered writeback bundle to the WB stage with valid/ready flow control.
- Flags out-of-range accesses.

Parameters:
- DEPTH, 10, number of memory words; valid word addresses are 0..DEPTH-1.
- DATA_W, 32, data/address width.
- REG_W, 5, destination register index width.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  EX result valid
- in_ready  out  1  stage can accept this cycle
- in_mem_read  in  1  load
- in_mem_write  in  1  store
- in_reg_write  in  1  instruction writes a register
- in_alu_result  in  DATA_W  effective address or ALU result
- in_store_data  in  DATA_W  store data
- in_rd  in  REG_W  destination register
- mem_read  out  1  memory read strobe, registered
- mem_write  out  1  memory write enable, registered
- mem_address  out  DATA_W  memory word address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_rdata  in  DATA_W  memory read data
- wb_valid  out  1  writeback bundle valid
- wb_ready  in  1  WB stage accepts
- wb_reg_write  out  1  register write enable for WB
- wb_rd  out  REG_W  destination register
- wb_data  out  DATA_W  load data or ALU result
- wb_fault  out  1  access was out of range or illegal

Behaviour:
- Only one clock: clk. Reset is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - mem_read, mem_write, wb_valid, wb_reg_write and wb_fault = 0.
  - mem_address, mem_wdata, wb_rd and wb_data = 0.
- Handshake:
  - Accept = in_valid & in_ready.
  - in_ready = (state==IDLE) | (state==OUT & wb_ready); this allows back-to-back flow.
  - The output bundle is held stable while wb_valid & ~wb_ready.
- Fault condition, evaluated at accept:
  - Fault if (in_mem_read | in_mem_write) & in_alu_result >= DEPTH.
  - Fault if in_mem_read & in_mem_write.
  - On fault: no memory strobe is issued; go to OUT with wb_fault=1, wb_reg_write=0, wb_data=in_alu_result.
- FSM states: IDLE, RD, WR, OUT.
  - IDLE/OUT + accept, ALU-only: go to OUT next cycle with wb_data = in_alu_result, wb_reg_write = in_reg_write.
  - IDLE/OUT + accept, load: go to RD. mem_read=1 and mem_address=in_alu_result for exactly one cycle.
  - IDLE/OUT + accept, store: go to WR. mem_write=1, mem_address=in_alu_result and mem_wdata=in_store_data for exactly one cycle.
  - RD: at the end of the cycle, latch mem_rdata into wb_data. mem_read returns to 0. Go to OUT with wb_reg_write=in_reg_write (captured at accept).
  - WR: mem_write returns to 0. Go to OUT with wb_reg_write=0 and wb_data=store address.
  - OUT: wb_valid=1. If wb_ready is high and there is no new accept, go to IDLE with wb_valid=0.
- Latency, accept at cycle N:
  - ALU-only and fault: wb_valid at N+1.
  - Load and store: wb_valid at N+2.
  - Throughput with wb_ready held high: 1/cycle for ALU ops, 1 per 2 cycles for loads and stores.
- mem_read always has at least one low cycle between loads, so every load produces a fresh rising edge.
- wb_rd is captured from in_rd at accept, for all instruction types.
- Reset mid-operation:
  - Asserted in RD: the load is discarded and no wb_valid is produced.
  - Asserted in WR: the write is still committed on that edge (mem_write already high), but no wb_valid is produced.
  - Asserted in OUT: the pending bundle is dropped.
- An accept while in OUT without wb_ready is impossible because in_ready=0 in that case.

Test Plan:
- Reset, then idle: all outputs 0; in_ready=1.
- Load at addr 2 with memory word 2 = 31 and rd=5: one-cycle mem_read pulse with mem_address=2. At N+2, wb_valid=1, wb_data=31, wb_rd=5, wb_reg_write=1, wb_fault=0.
- Store 99 to addr 4, then load from addr 4: mem_write high for exactly 1 cycle with mem_wdata=99. The following load returns wb_data=99, and mem_read shows two separate rising edges across back-to-back loads.
- Load from addr 10 (DEPTH=10): no mem_read or mem_write ever asserted. At N+1, wb_valid=1, wb_fault=1, wb_reg_write=0, wb_data=10.
- ALU op (result 7, rd=3) with wb_ready=0 for 3 cycles: wb_valid, wb_data=7 and wb_rd=3 are held stable and in_ready=0. When wb_ready rises, the bundle is retired and a queued ALU op is accepted the same cycle.
- Reset asserted during RD: no wb_valid afterwards and state returns to IDLE. Reset asserted during WR: the memory word is updated, no wb_valid, and outputs return to 0.
